uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_fifo.sv | 53 +++++
 rtl/uart_tx_fifo.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: parity modes, FSM states
// and the parity helper.
package uart_pkg;

  localparam int unsigned ParityNone = 0;
  localparam int unsigned ParityOdd  = 1;
  localparam int unsigned ParityEven = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // Payload must be zero-extended; unused upper bits then leave the XOR unchanged.
  function automatic logic calc_parity(input logic [7:0] payload, input int unsigned mode);
    return (mode == ParityOdd) ? ~^payload : ^payload;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with wrapping pointers; pushes are refused when full and pops when empty.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a character FIFO; frames are sent back-to-back while the
// queue is non-empty.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          serial_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BitCycles = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned BaudW     = $clog2(BitCycles);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(BitCycles - 1);
  localparam logic [2:0] DataLast = 3'(DATA_BITS - 1);
  localparam logic [2:0] StopLast = 3'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $fatal(1, "uart_tx_fifo: DATA_BITS must be in 5..8");
  end
  if (PARITY > ParityEven) begin : g_bad_parity
    $fatal(1, "uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
  end
  if (BitCycles < 2) begin : g_bad_baud
    $fatal(1, "uart_tx_fifo: CLOCK_FREQ/BAUD_RATE must be at least 2");
  end

  tx_state_e            state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 line_q, line_d;
  logic                 bit_done;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  assign data_in_ready = ~fifo_full;
  assign fifo_push     = data_in_valid & data_in_ready;
  assign bit_done      = (baud_q == BaudLast);
  assign serial_out    = line_q;
  assign tx_busy       = (state_q != StIdle);

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (data_in),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    line_d   = line_q;
    fifo_pop = 1'b0;

    if (state_q != StIdle) baud_d = bit_done ? '0 : baud_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        line_d = 1'b1;
        if (!fifo_empty) fifo_pop = 1'b1;
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          idx_d   = '0;
          line_d  = shift_q[0];
        end
      end
      StData: begin
        if (bit_done) begin
          if (idx_q == DataLast) begin
            if (PARITY != ParityNone) begin
              state_d = StParity;
              line_d  = parity_q;
            end else begin
              state_d = StStop;
              idx_d   = '0;
              line_d  = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            line_d  = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          state_d = StStop;
          idx_d   = '0;
          line_d  = 1'b1;
        end
      end
      StStop: begin
        if (bit_done) begin
          if (idx_q == StopLast) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
            end else begin
              state_d = StIdle;
              line_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A pop always launches a new frame, whether from idle or straight out of a stop bit.
    if (fifo_pop) begin
      state_d  = StStart;
      baud_d   = '0;
      line_d   = 1'b0;
      shift_d  = fifo_rdata;
      parity_d = calc_parity(8'(fifo_rdata), PARITY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      line_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      line_q   <= line_d;
    end
  end

endmodule
